guess_round_ctrl: RTL and testbench
===================================

GUESS_ROUND_CTRL -- requirements
Module: guess_round_ctrl

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clk (input, 1, rising-edge clock) and restart (input, 1, synchronous active-high reset).
REQ-002 The block SHALL have these inputs:
- confirmButton (1): debounced guess-confirm level.
- tick_1hz (1): one-cycle pulse, once per second.
- guess (10): unsigned binary player guess.
- diff_timer (2): 0 = idle/win/gameover; 1/2/3 = level.
- Max_digit (2): digit count of secret, 1..3.
- Max_incorrect_guesses (3): lockout threshold.
REQ-003 The block SHALL have these outputs:
- round (3): correct guesses in the current level.
- incorrect_guesses (3): wrong guesses in the current level.
- timer (7): seconds remaining.
- hint (2): last guess result; 00 none, 01 low, 10 high, 11 correct.
- correct_pulse (1): one-cycle flag on a correct guess.
- target (10): current secret.

Function
REQ-004 The block SHALL run a 10-bit Fibonacci LFSR with polynomial x^10+x^7+1, advancing every clock and seeded to 10'h001 on restart.
REQ-005 The block SHALL set limit to 10, 100 or 1000 for Max_digit = 1, 2 or 3, and to 1 for Max_digit = 0.
REQ-006 On a "new target" event, the block SHALL form cand from the LFSR bits, using [3:0], [6:0] or [9:0] for Max_digit = 1, 2 or 3.
- target SHALL load cand when cand < limit, else cand − limit.
- The result SHALL always be less than limit.
REQ-007 The block SHALL register diff_timer into diff_q every cycle; a level change is diff_timer != diff_q.
REQ-008 On a level change, the block SHALL in the same edge:
- load timer with 30, 60 or 90 for diff_timer = 1, 2 or 3, and 0 for diff_timer = 0;
- clear round, incorrect_guesses and hint;
- generate a new target.
REQ-009 The block SHALL register confirmButton into conf_q; a press is confirmButton & ~conf_q, and there SHALL be one press per rising edge of the level.
REQ-010 A press SHALL be accepted only when all of the following hold: no level change that cycle, diff_timer != 0, timer > 0, incorrect_guesses < Max_incorrect_guesses, and round < 5. Otherwise the press SHALL be ignored and all outputs held.
REQ-011 An accepted press SHALL update outputs at the same clock edge that detects it (one-cycle latency from the confirmButton rise).
- guess == target: hint = 11, round +1, correct_pulse = 1 for one cycle, and a new target generated.
- guess < target: hint = 01, incorrect_guesses +1.
- guess > target: hint = 10, incorrect_guesses +1; this includes guess ≥ limit.
REQ-012 round SHALL saturate at 5 and incorrect_guesses SHALL saturate at 7.
REQ-013 Once round = 5, the block SHALL hold round until the next level change, so that the level controller sees round > 4 on the following confirm.
REQ-014 When tick_1hz = 1, timer > 0, diff_timer != 0 and there is no level change, timer SHALL decrement by 1; timer SHALL never wrap below 0.
REQ-015 A level change SHALL take priority over a simultaneous press and a simultaneous tick; both SHALL be discarded that cycle.
REQ-016 A tick and an accepted press in the same cycle SHALL both take effect.
REQ-017 correct_pulse SHALL be 0 in every cycle other than the one following an accepted correct guess.

Reset
REQ-018 While restart = 1 at a rising edge, the block SHALL clear round, incorrect_guesses, timer, hint, correct_pulse, target, diff_q and conf_q to 0, and set the LFSR to 10'h001.
REQ-019 restart SHALL override every other event, including in the middle of a level.
REQ-020 On the first cycle after restart, a nonzero diff_timer SHALL be treated as a level change per REQ-008.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- Restart, then diff_timer=1, Max_digit=1 -> next edge timer=30, round=0, incorrect_guesses=0, target<10.
- Press with guess=target -> hint=11, round=1, correct_pulse high for exactly one cycle, new target<10; hold confirmButton high for 5 cycles -> only one press counted.
- Max_incorrect_guesses=3, three presses with guess=target+1 -> hint=10, incorrect_guesses=3; a fourth press -> no change.
- Max_digit=3, guess=1023 -> hint=10, incorrect_guesses+1; target always <1000 over 2000 level loads.
- Level 1, 31 ticks -> timer 30..0 and stays 0; a press at timer=0 is ignored.
- round=5, then diff_timer 1->2 coincident with a press and a tick -> round=0, timer=60, hint=00, press not evaluated; restart mid-level -> all outputs 0 at the next edge.

Source files
------------

// File: rtl/guess_round_ctrl.sv
// Round controller for the number-guessing game: secret generation, guess
// evaluation, per-level countdown timer and correct/incorrect bookkeeping.
module guess_round_ctrl (
  input  logic       clk,
  input  logic       restart,
  input  logic       confirmButton,
  input  logic       tick_1hz,
  input  logic [9:0] guess,
  input  logic [1:0] diff_timer,
  input  logic [1:0] Max_digit,
  input  logic [2:0] Max_incorrect_guesses,
  output logic [2:0] round,
  output logic [2:0] incorrect_guesses,
  output logic [6:0] timer,
  output logic [1:0] hint,
  output logic       correct_pulse,
  output logic [9:0] target
);

  localparam logic [1:0] HINT_NONE = 2'b00;
  localparam logic [1:0] HINT_LOW  = 2'b01;
  localparam logic [1:0] HINT_HIGH = 2'b10;
  localparam logic [1:0] HINT_OK   = 2'b11;
  localparam logic [2:0] ROUND_MAX = 3'd5;
  localparam logic [2:0] INC_MAX   = 3'd7;

  logic [9:0] r_lfsr;
  logic [1:0] r_diff_q;
  logic       r_conf_q;
  logic [2:0] r_round;
  logic [2:0] r_inc;
  logic [6:0] r_timer;
  logic [1:0] r_hint;
  logic       r_pulse;
  logic [9:0] r_target;

  logic [9:0] w_lfsr_next;
  logic [9:0] w_limit;
  logic [9:0] w_cand;
  logic [9:0] w_new_target;
  logic [6:0] w_level_time;
  logic       w_level_change;
  logic       w_press;
  logic       w_accept;
  logic       w_tick_dec;

  // Fibonacci LFSR, taps 10 and 7
  assign w_lfsr_next = {r_lfsr[8:0], r_lfsr[9] ^ r_lfsr[6]};

  // A single conditional subtract suffices: the widest candidate is < 2*limit
  always_comb begin
    w_limit = 10'd1;
    w_cand  = '0;
    case (Max_digit)
      2'd1: begin
        w_limit = 10'd10;
        w_cand  = {6'd0, r_lfsr[3:0]};
      end
      2'd2: begin
        w_limit = 10'd100;
        w_cand  = {3'd0, r_lfsr[6:0]};
      end
      2'd3: begin
        w_limit = 10'd1000;
        w_cand  = r_lfsr;
      end
      default: ;
    endcase
    w_new_target = (w_cand < w_limit) ? w_cand : (w_cand - w_limit);
  end

  always_comb begin
    w_level_time = 7'd0;
    case (diff_timer)
      2'd1:    w_level_time = 7'd30;
      2'd2:    w_level_time = 7'd60;
      2'd3:    w_level_time = 7'd90;
      default: w_level_time = 7'd0;
    endcase
  end

  assign w_level_change = (diff_timer != r_diff_q);
  assign w_press        = confirmButton & ~r_conf_q;
  assign w_accept       = w_press & ~w_level_change & (diff_timer != 2'd0) &
                          (r_timer != 7'd0) & (r_inc < Max_incorrect_guesses) &
                          (r_round < ROUND_MAX);
  assign w_tick_dec     = tick_1hz & ~w_level_change & (diff_timer != 2'd0) &
                          (r_timer != 7'd0);

  always_ff @(posedge clk) begin
    if (restart) begin
      r_lfsr   <= 10'h001;
      r_diff_q <= '0;
      r_conf_q <= 1'b0;
      r_round  <= '0;
      r_inc    <= '0;
      r_timer  <= '0;
      r_hint   <= HINT_NONE;
      r_pulse  <= 1'b0;
      r_target <= '0;
    end else begin
      r_lfsr   <= w_lfsr_next;
      r_diff_q <= diff_timer;
      r_conf_q <= confirmButton;
      r_pulse  <= 1'b0;
      if (w_level_change) begin
        r_timer  <= w_level_time;
        r_round  <= '0;
        r_inc    <= '0;
        r_hint   <= HINT_NONE;
        r_target <= w_new_target;
      end else begin
        if (w_tick_dec)
          r_timer <= r_timer - 7'd1;
        if (w_accept) begin
          if (guess == r_target) begin
            r_hint   <= HINT_OK;
            r_round  <= (r_round == ROUND_MAX) ? ROUND_MAX : r_round + 3'd1;
            r_pulse  <= 1'b1;
            r_target <= w_new_target;
          end else begin
            r_hint <= (guess < r_target) ? HINT_LOW : HINT_HIGH;
            r_inc  <= (r_inc == INC_MAX) ? INC_MAX : r_inc + 3'd1;
          end
        end
      end
    end
  end

  assign round             = r_round;
  assign incorrect_guesses = r_inc;
  assign timer             = r_timer;
  assign hint              = r_hint;
  assign correct_pulse     = r_pulse;
  assign target            = r_target;

endmodule

// File: tb/tb_guess_round_ctrl.sv
// Bench for guess_round_ctrl: directed scenarios plus randomized play, all
// outputs compared every cycle against an integer-level game model.
module tb_guess_round_ctrl;

  logic       clk = 1'b0;
  logic       restart;
  logic       confirmButton;
  logic       tick_1hz;
  logic [9:0] guess;
  logic [1:0] diff_timer;
  logic [1:0] Max_digit;
  logic [2:0] Max_incorrect_guesses;
  logic [2:0] round;
  logic [2:0] incorrect_guesses;
  logic [6:0] timer;
  logic [1:0] hint;
  logic       correct_pulse;
  logic [9:0] target;

  int n_checks = 0;
  int n_errors = 0;

  guess_round_ctrl dut (.*);

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Game model: plain integers describing the rules, updated once per edge
  int m_lfsr, m_diff_q, m_conf_q, m_round, m_inc, m_timer, m_hint, m_pulse, m_target;
  bit m_valid = 0;

  function automatic int cand_bits(input int d);
    return (d == 3) ? 10 : (d == 2) ? 7 : (d == 1) ? 4 : 0;
  endfunction

  function automatic int digit_limit(input int d);
    return (d == 0) ? 1 : (d == 1) ? 10 : (d == 2) ? 100 : 1000;
  endfunction

  always @(posedge clk) begin
    int lim, cand, nt, fb, t_before;
    bit lvl, press, ok;
    if (restart) begin
      m_lfsr = 1; m_diff_q = 0; m_conf_q = 0; m_round = 0; m_inc = 0;
      m_timer = 0; m_hint = 0; m_pulse = 0; m_target = 0; m_valid = 1;
    end else if (m_valid) begin
      lim   = digit_limit(int'(Max_digit));
      cand  = m_lfsr % (1 << cand_bits(int'(Max_digit)));
      nt    = (cand >= lim) ? cand - lim : cand;
      lvl   = (int'(diff_timer) != m_diff_q);
      press = confirmButton && !m_conf_q;
      t_before = m_timer;
      m_pulse  = 0;
      if (lvl) begin
        m_timer = 30 * int'(diff_timer);
        m_round = 0; m_inc = 0; m_hint = 0; m_target = nt;
      end else begin
        ok = press && diff_timer != 0 && t_before > 0 &&
             m_inc < int'(Max_incorrect_guesses) && m_round < 5;
        if (tick_1hz && diff_timer != 0 && t_before > 0) m_timer = t_before - 1;
        if (ok) begin
          if (int'(guess) == m_target) begin
            m_hint = 3; m_round = (m_round >= 5) ? 5 : m_round + 1;
            m_pulse = 1; m_target = nt;
          end else begin
            m_hint = (int'(guess) < m_target) ? 1 : 2;
            m_inc  = (m_inc >= 7) ? 7 : m_inc + 1;
          end
        end
      end
      m_diff_q = int'(diff_timer);
      m_conf_q = int'(confirmButton);
      fb = ((m_lfsr >> 9) ^ (m_lfsr >> 6)) & 1;
      m_lfsr = ((m_lfsr << 1) | fb) & 10'h3ff;
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("model_round", round, m_round);
      chk("model_incorrect", incorrect_guesses, m_inc);
      chk("model_timer", timer, m_timer);
      chk("model_hint", hint, m_hint);
      chk("model_pulse", correct_pulse, m_pulse);
      chk("model_target", target, m_target);
    end
  end

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic press_with(input int g);
    guess = 10'(g); confirmButton = 1'b1;
    cyc();
    confirmButton = 1'b0;
  endtask

  initial begin
    restart = 1; confirmButton = 0; tick_1hz = 0; guess = 0;
    diff_timer = 0; Max_digit = 0; Max_incorrect_guesses = 0;
    cyc(); cyc();

    // Level 1 entry
    restart = 0; diff_timer = 1; Max_digit = 1; Max_incorrect_guesses = 3;
    cyc();
    chk("l1_timer", timer, 30);
    chk("l1_round", round, 0);
    chk("l1_inc", incorrect_guesses, 0);
    chk("l1_target_lt10", target < 10, 1);
    chk("l1_target_seed", target, 1);

    // Correct guess, then a long hold counts only once
    guess = 10'(m_target); confirmButton = 1;
    cyc();
    chk("ok_hint", hint, 3);
    chk("ok_round", round, 1);
    chk("ok_pulse", correct_pulse, 1);
    chk("ok_new_target_lt10", target < 10, 1);
    guess = 10'(m_target);
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("hold_pulse", correct_pulse, 0);
      chk("hold_round", round, 1);
    end
    confirmButton = 0; cyc();

    // Three high guesses reach the lockout, a fourth does nothing
    for (int i = 0; i < 3; i++) begin
      press_with(m_target + 1); cyc();
    end
    chk("high_hint", hint, 2);
    chk("high_inc", incorrect_guesses, 3);
    press_with(m_target + 1); cyc();
    chk("lockout_inc", incorrect_guesses, 3);
    chk("lockout_round", round, 1);

    // Three-digit level: out-of-range guess is high
    diff_timer = 3; Max_digit = 3;
    cyc();
    chk("l3_timer", timer, 90);
    chk("l3_target_lt1000", target < 1000, 1);
    press_with(1023);
    chk("big_hint", hint, 2);
    chk("big_inc", incorrect_guesses, 1);
    for (int i = 0; i < 2000; i++) begin
      diff_timer = (i % 2 == 0) ? 2'd1 : 2'd3;
      cyc();
      chk("load_target_lt1000", target < 1000, 1);
    end

    // Countdown to zero and stays there; press at zero ignored
    restart = 1; diff_timer = 1; Max_digit = 1; Max_incorrect_guesses = 3;
    cyc();
    restart = 0;
    cyc();
    chk("t_start", timer, 30);
    for (int k = 1; k <= 31; k++) begin
      tick_1hz = 1; cyc();
      chk("t_count", timer, (k > 30) ? 0 : 30 - k);
    end
    tick_1hz = 1; cyc(); cyc(); tick_1hz = 0;
    chk("t_floor", timer, 0);
    press_with(m_target); cyc();
    chk("t0_round", round, 0);
    chk("t0_hint", hint, 0);

    // Five wins, then level change beats a coincident press and tick
    restart = 1; cyc();
    restart = 0; Max_incorrect_guesses = 7; cyc();
    for (int i = 0; i < 5; i++) begin
      press_with(m_target); cyc();
    end
    chk("r5_round", round, 5);
    press_with(m_target); cyc();
    chk("r5_hold", round, 5);
    diff_timer = 2; guess = 10'(m_target); confirmButton = 1; tick_1hz = 1;
    cyc();
    confirmButton = 0; tick_1hz = 0;
    chk("lc_round", round, 0);
    chk("lc_timer", timer, 60);
    chk("lc_hint", hint, 0);
    chk("lc_pulse", correct_pulse, 0);
    cyc(); cyc();
    restart = 1; cyc();
    chk("rst_round", round, 0);
    chk("rst_inc", incorrect_guesses, 0);
    chk("rst_timer", timer, 0);
    chk("rst_hint", hint, 0);
    chk("rst_pulse", correct_pulse, 0);
    chk("rst_target", target, 0);
    restart = 0; cyc();
    chk("post_rst_timer", timer, 60);

    // Randomized play against the model
    for (int i = 0; i < 4000; i++) begin
      int r;
      restart = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 59) == 0) begin
        diff_timer = 2'($urandom_range(0, 3));
        Max_digit  = 2'($urandom_range(0, 3));
        Max_incorrect_guesses = 3'($urandom_range(0, 7));
      end
      if ($urandom_range(0, 2) == 0) confirmButton = ~confirmButton;
      r = $urandom_range(0, 3);
      case (r)
        0: guess = 10'(m_target);
        1: guess = 10'(m_target + 1);
        2: guess = 10'((m_target > 0) ? m_target - 1 : 0);
        default: guess = 10'($urandom_range(0, 1023));
      endcase
      tick_1hz = ($urandom_range(0, 3) == 0);
      cyc();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
